fpu_mul_arbiter: RTL

- Shares one pipelined single-precision multiplier among NREQ requesters.
- Per-requester valid/ready operand ports, round-robin grant.
- Tracks in-flight operations through the multiplier's fixed latency and buffers results, with requester id, in an in-order result FIFO with valid/ready output.
- Credit-based issue guarantees the FIFO never overflows.
- Drives the multiplier's synchronous active-high reset, including a post-reset flush.

---
 rtl/fpu_mul_arbiter.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/fpu_mul_arbiter.sv
// Shares one pipelined FP32 multiplier among NREQ round-robin requesters, tracks in-flight ops
// through the fixed latency and returns tagged results through an in-order, credit-limited FIFO.
// Optional per-result {nan, inf, zero} flags are enabled with `define FPU_MUL_ARB_FLAGS_EN.

module fpu_mul_arbiter_chk (
    input logic clk,
    input logic rst,
    input logic push,
    input logic full
);
    // Issue credits must make a push into a full FIFO impossible
    assert property (@(posedge clk) disable iff (!rst) !(push && full))
        else $error("fpu_mul_arbiter: result FIFO push while full");
endmodule

module fpu_mul_arbiter #(
    parameter int NREQ  = 4,
    parameter int LAT   = 3,
    parameter int DEPTH = 8,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [32*NREQ-1:0]   req_a,
    input  logic [32*NREQ-1:0]   req_b,
    output logic                 mul_rst,
    output logic [31:0]          mul_a,
    output logic [31:0]          mul_b,
    input  logic [31:0]          mul_s,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [31:0]          res_s,
    output logic [IDW-1:0]       res_id,
    output logic [2:0]           res_flags,
    output logic                 busy
);
    localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW  = $clog2(DEPTH + LAT + 1) + 1;
    localparam int FCW = $clog2(LAT + 1) + 1;

    typedef enum logic [0:0] {ST_FLUSH = 1'b0, ST_RUN = 1'b1} state_t;

    state_t           state_r, state_s;
    logic [FCW-1:0]   flush_cnt_r, flush_cnt_s;
    logic             mul_rst_r;
    logic [IDW-1:0]   rr_r;
    logic [LAT-1:0]   vpipe_r;
    logic [IDW-1:0]   idpipe_r [LAT];
    logic [PW-1:0]    wr_ptr_r, rd_ptr_r;
    logic [CW-1:0]    fifo_count_r;
    logic [31:0]      mem_data_r [DEPTH];
    logic [IDW-1:0]   mem_id_r [DEPTH];

    logic             found_s, hit_s, run_s, issue_ok_s, accept_s, push_s, pop_s;
    logic [IDW-1:0]   gnt_s;
    int               idx_s;
    logic [CW-1:0]    inflight_s, occ_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        ptr_inc = (p == PW'(DEPTH - 1)) ? {PW{1'b0}} : p + PW'(1);
    endfunction

    // Flush sequencing: hold the multiplier in reset for LAT+1 cycles after every reset
    always_comb begin
        state_s     = state_r;
        flush_cnt_s = flush_cnt_r;
        case (state_r)
            ST_FLUSH: begin
                if (flush_cnt_r == FCW'(LAT)) begin
                    state_s     = ST_RUN;
                    flush_cnt_s = {FCW{1'b0}};
                end else begin
                    state_s     = ST_FLUSH;
                    flush_cnt_s = flush_cnt_r + FCW'(1);
                end
            end
            ST_RUN: begin
                state_s     = ST_RUN;
                flush_cnt_s = {FCW{1'b0}};
            end
            default: begin
                state_s     = ST_FLUSH;
                flush_cnt_s = {FCW{1'b0}};
            end
        endcase
    end

    // FSM state, flush counter and registered multiplier reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_FLUSH;
            flush_cnt_r <= {FCW{1'b0}};
            mul_rst_r   <= 1'b1;
        end else begin
            state_r     <= state_s;
            flush_cnt_r <= flush_cnt_s;
            mul_rst_r   <= (state_s == ST_FLUSH);
        end
    end

    assign mul_rst = mul_rst_r;

    // Round-robin search starting at rr_r, wrapping at NREQ
    always_comb begin
        found_s = 1'b0;
        gnt_s   = {IDW{1'b0}};
        idx_s   = 0;
        hit_s   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            idx_s   = int'(rr_r) + i;
            idx_s   = (idx_s >= NREQ) ? idx_s - NREQ : idx_s;
            hit_s   = !found_s && req_valid[idx_s];
            gnt_s   = hit_s ? IDW'(idx_s) : gnt_s;
            found_s = found_s | hit_s;
        end
    end

    // Credit check, handshake and operand mux; a same-cycle pop does not free a credit
    always_comb begin
        inflight_s = {CW{1'b0}};
        for (int i = 0; i < LAT; i++) begin
            inflight_s = inflight_s + CW'(vpipe_r[i]);
        end
        occ_s      = fifo_count_r + inflight_s;
        issue_ok_s = (occ_s < CW'(DEPTH));
        run_s      = (state_r == ST_RUN);
        accept_s   = run_s & found_s & issue_ok_s;
        req_ready        = {NREQ{1'b0}};
        req_ready[gnt_s] = accept_s;
        mul_a = accept_s ? req_a[{gnt_s, 5'b00000} +: 32] : 32'h0000_0000;
        mul_b = accept_s ? req_b[{gnt_s, 5'b00000} +: 32] : 32'h0000_0000;
    end

    // Round-robin pointer and in-flight {valid, id} tracking pipe
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_r    <= {IDW{1'b0}};
            vpipe_r <= {LAT{1'b0}};
            for (int i = 0; i < LAT; i++) begin
                idpipe_r[i] <= {IDW{1'b0}};
            end
        end else begin
            if (accept_s) begin
                rr_r <= (gnt_s == IDW'(NREQ - 1)) ? {IDW{1'b0}} : gnt_s + IDW'(1);
            end
            vpipe_r[0]  <= accept_s;
            idpipe_r[0] <= gnt_s;
            for (int i = 1; i < LAT; i++) begin
                vpipe_r[i]  <= vpipe_r[i-1];
                idpipe_r[i] <= idpipe_r[i-1];
            end
        end
    end

    assign push_s    = vpipe_r[LAT-1];
    assign res_valid = (fifo_count_r != {CW{1'b0}});
    assign pop_s     = res_valid & res_ready;

    // Result FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r     <= {PW{1'b0}};
            rd_ptr_r     <= {PW{1'b0}};
            fifo_count_r <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({push_s, pop_s})
                2'b10:   fifo_count_r <= fifo_count_r + CW'(1);
                2'b01:   fifo_count_r <= fifo_count_r - CW'(1);
                default: fifo_count_r <= fifo_count_r;
            endcase
        end
    end

    // Result storage; entries are only visible while counted, so no reset is needed
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_data_r[wr_ptr_r] <= mul_s;
            mem_id_r[wr_ptr_r]   <= idpipe_r[LAT-1];
        end
    end

    assign res_s  = res_valid ? mem_data_r[rd_ptr_r] : 32'h0000_0000;
    assign res_id = res_valid ? mem_id_r[rd_ptr_r] : {IDW{1'b0}};
    assign busy   = (|vpipe_r) | res_valid;

`ifdef FPU_MUL_ARB_FLAGS_EN
    logic [2:0] mem_flags_r [DEPTH];

    function automatic logic [2:0] fp_class(input logic [31:0] v);
        fp_class[2] = (v[30:23] == 8'hff) && (v[22:0] != 23'h0);
        fp_class[1] = (v[30:23] == 8'hff) && (v[22:0] == 23'h0);
        fp_class[0] = (v[30:23] == 8'h00) && (v[22:0] == 23'h0);
    endfunction

    // Classify each product as it enters the FIFO
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_flags_r[wr_ptr_r] <= fp_class(mul_s);
        end
    end

    assign res_flags = res_valid ? mem_flags_r[rd_ptr_r] : 3'b000;
`else
    assign res_flags = 3'b000;
`endif

    fpu_mul_arbiter_chk u_chk (
        .clk  (clk),
        .rst  (rst),
        .push (push_s),
        .full (fifo_count_r == CW'(DEPTH))
    );
endmodule
